// File: rtl/stage_wb_hist.sv
// stage_wb_hist: write-back stage with a multi-entry history of retired writes.
// Selects the register-file write data, drives the RF write port, and keeps the
// last HIST_DEPTH writes so later stages can forward operands from them.
// Optional feature: define WB_LOAD_EXT_EN to extract and extend load data by
// i_wb_ld_fmt/i_wb_ld_off before the data select; otherwise memory data passes through.
module stage_wb_hist #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int HIST_DEPTH = 2,
   parameter int NUM_LOOKUP = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         i_flush,
   input  logic [DATA_W-1:0]            i_wb_pc,
   input  logic [DATA_W-1:0]            i_wb_data_o_ma,
   input  logic [DATA_W-1:0]            i_wb_alu_rslt,
   input  logic [2:0]                   i_wb_cntrl,
   input  logic [REG_AW-1:0]            i_wb_rdst,
   input  logic [2:0]                   i_wb_ld_fmt,
   input  logic [1:0]                   i_wb_ld_off,
   output logic [REG_AW-1:0]            o_wb_rdst,
   output logic                         o_wb_reg_write_rf,
   output logic [DATA_W-1:0]            o_wb_mux,
   output logic [1:0]                   o_wb_reg_dst_s,
   output logic [REG_AW-1:0]            o_vwb_rdst,
   output logic                         o_vwb_reg_write_rf,
   output logic [DATA_W-1:0]            o_vwb_mux,
   input  logic [NUM_LOOKUP*REG_AW-1:0] i_lk_reg,
   output logic [NUM_LOOKUP-1:0]        o_lk_hit,
   output logic [NUM_LOOKUP*DATA_W-1:0] o_lk_data
);

   localparam int WB_R_WE = 2;

   localparam logic [1:0] SEL_MEM  = 2'b00;
   localparam logic [1:0] SEL_ALU  = 2'b01;
   localparam logic [1:0] SEL_PC   = 2'b10;

   localparam logic [2:0] FMT_BYTE_S = 3'b001;
   localparam logic [2:0] FMT_BYTE_U = 3'b010;
   localparam logic [2:0] FMT_HALF_S = 3'b011;
   localparam logic [2:0] FMT_HALF_U = 3'b100;

   logic [1:0]        sel;
   logic              wb_we;
   logic [DATA_W-1:0] mem_val;

   logic              hist_valid [HIST_DEPTH];
   logic [REG_AW-1:0] hist_rdst  [HIST_DEPTH];
   logic [DATA_W-1:0] hist_data  [HIST_DEPTH];

   assign sel   = i_wb_cntrl[1:0];
   assign wb_we = i_wb_cntrl[WB_R_WE];

   assign o_wb_rdst         = i_wb_rdst;
   assign o_wb_reg_write_rf = wb_we;
   assign o_wb_reg_dst_s    = sel;

`ifdef WB_LOAD_EXT_EN
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Pick the addressed little-endian lane and extend it per the load format
   always_comb begin
      ld_byte = i_wb_data_o_ma[{i_wb_ld_off, 3'b000} +: 8];
      ld_half = i_wb_data_o_ma[{i_wb_ld_off[1], 4'b0000} +: 16];
      case (i_wb_ld_fmt)
         FMT_BYTE_S: mem_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         FMT_BYTE_U: mem_val = {{(DATA_W-8){1'b0}}, ld_byte};
         FMT_HALF_S: mem_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
         FMT_HALF_U: mem_val = {{(DATA_W-16){1'b0}}, ld_half};
         default:    mem_val = i_wb_data_o_ma;
      endcase
   end
`else
   logic unused_ld;
   assign unused_ld = ^{i_wb_ld_fmt, i_wb_ld_off, FMT_BYTE_S, FMT_BYTE_U, FMT_HALF_S, FMT_HALF_U};
   assign mem_val   = i_wb_data_o_ma;
`endif

   // Write-data select: memory, ALU, PC or zero
   always_comb begin
      case (sel)
         SEL_MEM: o_wb_mux = mem_val;
         SEL_ALU: o_wb_mux = i_wb_alu_rslt;
         SEL_PC:  o_wb_mux = i_wb_pc;
         default: o_wb_mux = '0;
      endcase
   end

   // History shift register; flush drops all valids and beats stall, r0 writes never become valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_valid[k] <= 1'b0;
            hist_rdst[k]  <= '0;
            hist_data[k]  <= '0;
         end
      end else if (i_flush) begin
         for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_valid[k] <= 1'b0;
         end
      end else if (!stall) begin
         hist_valid[0] <= wb_we && (i_wb_rdst != '0);
         hist_rdst[0]  <= i_wb_rdst;
         hist_data[0]  <= o_wb_mux;
         for (int k = 1; k < HIST_DEPTH; k++) begin
            hist_valid[k] <= hist_valid[k-1];
            hist_rdst[k]  <= hist_rdst[k-1];
            hist_data[k]  <= hist_data[k-1];
         end
      end
   end

   assign o_vwb_reg_write_rf = hist_valid[HIST_DEPTH-1];
   assign o_vwb_rdst         = hist_rdst[HIST_DEPTH-1];
   assign o_vwb_mux          = hist_data[HIST_DEPTH-1];

   logic [REG_AW-1:0] lk_reg;
   logic              lk_hit;
   logic [DATA_W-1:0] lk_data;

   // Forwarding search: scan oldest to youngest then the current stage, so the youngest match wins
   always_comb begin
      o_lk_hit  = '0;
      o_lk_data = '0;
      lk_reg    = '0;
      lk_hit    = 1'b0;
      lk_data   = '0;
      for (int p = 0; p < NUM_LOOKUP; p++) begin
         lk_reg  = i_lk_reg[p*REG_AW +: REG_AW];
         lk_hit  = 1'b0;
         lk_data = '0;
         for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (hist_valid[k] && (hist_rdst[k] == lk_reg)) begin
               lk_hit  = 1'b1;
               lk_data = hist_data[k];
            end
         end
         if (wb_we && (i_wb_rdst == lk_reg)) begin
            lk_hit  = 1'b1;
            lk_data = o_wb_mux;
         end
         if (lk_reg == '0) begin
            lk_hit  = 1'b0;
            lk_data = '0;
         end
         o_lk_hit[p]                  = lk_hit;
         o_lk_data[p*DATA_W +: DATA_W] = lk_data;
      end
   end

endmodule

// File: tb/tb_stage_wb_hist.sv
// tb_stage_wb_hist: randomized and directed checks of stage_wb_hist against a
// queue-based reference model of the write-back history.
module tb_stage_wb_hist;

   localparam int DATA_W     = 32;
   localparam int REG_AW     = 5;
   localparam int HIST_DEPTH = 2;
   localparam int NUM_LOOKUP = 2;

   typedef struct {
      bit        valid;
      bit [4:0]  rdst;
      bit [31:0] data;
   } ent_t;

   typedef struct {
      bit [1:0]  sel;
      bit        we;
      bit [4:0]  rdst;
      bit [31:0] alu;
      bit [31:0] mem;
      bit [31:0] pc;
      bit [2:0]  fmt;
      bit [1:0]  off;
      bit        stall;
      bit        flush;
      bit [4:0]  lk0;
      bit [4:0]  lk1;
   } stim_t;

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic                         stall = 1'b0;
   logic                         i_flush = 1'b0;
   logic [DATA_W-1:0]            i_wb_pc = '0;
   logic [DATA_W-1:0]            i_wb_data_o_ma = '0;
   logic [DATA_W-1:0]            i_wb_alu_rslt = '0;
   logic [2:0]                   i_wb_cntrl = '0;
   logic [REG_AW-1:0]            i_wb_rdst = '0;
   logic [2:0]                   i_wb_ld_fmt = '0;
   logic [1:0]                   i_wb_ld_off = '0;
   logic [REG_AW-1:0]            o_wb_rdst;
   logic                         o_wb_reg_write_rf;
   logic [DATA_W-1:0]            o_wb_mux;
   logic [1:0]                   o_wb_reg_dst_s;
   logic [REG_AW-1:0]            o_vwb_rdst;
   logic                         o_vwb_reg_write_rf;
   logic [DATA_W-1:0]            o_vwb_mux;
   logic [NUM_LOOKUP*REG_AW-1:0] i_lk_reg = '0;
   logic [NUM_LOOKUP-1:0]        o_lk_hit;
   logic [NUM_LOOKUP*DATA_W-1:0] o_lk_data;

   int checks = 0;
   int errors = 0;

   ent_t  hist[$];
   stim_t cur;

   stage_wb_hist #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .HIST_DEPTH(HIST_DEPTH), .NUM_LOOKUP(NUM_LOOKUP)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .i_flush(i_flush),
      .i_wb_pc(i_wb_pc), .i_wb_data_o_ma(i_wb_data_o_ma), .i_wb_alu_rslt(i_wb_alu_rslt),
      .i_wb_cntrl(i_wb_cntrl), .i_wb_rdst(i_wb_rdst), .i_wb_ld_fmt(i_wb_ld_fmt),
      .i_wb_ld_off(i_wb_ld_off), .o_wb_rdst(o_wb_rdst), .o_wb_reg_write_rf(o_wb_reg_write_rf),
      .o_wb_mux(o_wb_mux), .o_wb_reg_dst_s(o_wb_reg_dst_s), .o_vwb_rdst(o_vwb_rdst),
      .o_vwb_reg_write_rf(o_vwb_reg_write_rf), .o_vwb_mux(o_vwb_mux),
      .i_lk_reg(i_lk_reg), .o_lk_hit(o_lk_hit), .o_lk_data(o_lk_data)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.sel = 2'b11; s.we = 1'b0; s.rdst = '0; s.alu = '0; s.mem = '0; s.pc = '0;
      s.fmt = '0; s.off = '0; s.stall = 1'b0; s.flush = 1'b0; s.lk0 = '0; s.lk1 = '0;
      return s;
   endfunction

   function automatic stim_t wr(input bit [4:0] r, input bit [31:0] v);
      stim_t s = idle();
      s.sel = 2'b01; s.we = 1'b1; s.rdst = r; s.alu = v;
      return s;
   endfunction

   // Loaded value as the load unit would deliver it
   function automatic bit [31:0] load_value(input bit [31:0] mem, input bit [2:0] fmt, input bit [1:0] off);
`ifdef WB_LOAD_EXT_EN
      bit [31:0] b = (mem >> (int'(off) * 8)) % 256;
      bit [31:0] h = (mem >> (int'(off / 2) * 16)) % 65536;
      case (fmt)
         3'd1:    return (b >= 128) ? b - 32'd256 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return h;
         default: return mem;
      endcase
`else
      if (fmt == 3'd7 && off == 2'd3) return mem;
      return mem;
`endif
   endfunction

   function automatic bit [31:0] model_mux(input stim_t s);
      case (s.sel)
         2'd0:    return load_value(s.mem, s.fmt, s.off);
         2'd1:    return s.alu;
         2'd2:    return s.pc;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {hit, data}: current stage first, then history youngest to oldest
   function automatic bit [32:0] model_lookup(input stim_t s, input bit [4:0] r);
      if (r == 0) return 33'd0;
      if (s.we && s.rdst == r) return {1'b1, model_mux(s)};
      foreach (hist[i]) begin
         if (hist[i].valid && hist[i].rdst == r) return {1'b1, hist[i].data};
      end
      return 33'd0;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (HIST_DEPTH) hist.push_back('{valid: 1'b0, rdst: 5'd0, data: 32'd0});
   endtask

   task automatic model_step(input stim_t s);
      ent_t e;
      if (s.flush) begin
         foreach (hist[i]) hist[i].valid = 1'b0;
      end else if (!s.stall) begin
         e.valid = s.we && (s.rdst != 0);
         e.rdst  = s.rdst;
         e.data  = model_mux(s);
         hist.push_front(e);
         void'(hist.pop_back());
      end
   endtask

   task automatic check_all(input stim_t s);
      bit [32:0] l0 = model_lookup(s, s.lk0);
      bit [32:0] l1 = model_lookup(s, s.lk1);
      checkOutput("wb_mux",    64'(o_wb_mux),           64'(model_mux(s)));
      checkOutput("wb_rdst",   64'(o_wb_rdst),          64'(s.rdst));
      checkOutput("wb_we",     64'(o_wb_reg_write_rf),  64'(s.we));
      checkOutput("wb_dst_s",  64'(o_wb_reg_dst_s),     64'(s.sel));
      checkOutput("vwb_we",    64'(o_vwb_reg_write_rf), 64'(hist[HIST_DEPTH-1].valid));
      checkOutput("vwb_rdst",  64'(o_vwb_rdst),         64'(hist[HIST_DEPTH-1].rdst));
      checkOutput("vwb_mux",   64'(o_vwb_mux),          64'(hist[HIST_DEPTH-1].data));
      checkOutput("lk0_hit",   64'(o_lk_hit[0]),        64'(l0[32]));
      checkOutput("lk0_data",  64'(o_lk_data[0 +: 32]), 64'(l0[31:0]));
      checkOutput("lk1_hit",   64'(o_lk_hit[1]),        64'(l1[32]));
      checkOutput("lk1_data",  64'(o_lk_data[32 +: 32]),64'(l1[31:0]));
   endtask

   // Drive one cycle of inputs after the falling edge and check the combinational view
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      cur            = s;
      stall          = s.stall;
      i_flush        = s.flush;
      i_wb_pc        = s.pc;
      i_wb_data_o_ma = s.mem;
      i_wb_alu_rslt  = s.alu;
      i_wb_cntrl     = {s.we, s.sel};
      i_wb_rdst      = s.rdst;
      i_wb_ld_fmt    = s.fmt;
      i_wb_ld_off    = s.off;
      i_lk_reg       = {s.lk1, s.lk0};
      #1;
      check_all(s);
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_step(cur);
   endtask

   task automatic cycle(input stim_t s);
      applyStimulus(s);
      clock_edge();
   endtask

   // Directed scenarios followed by a randomized run
   initial begin
      stim_t s;
      ent_t  held;
      model_reset();
      cur = idle();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      applyStimulus(idle());
      checkOutput("reset_vwb_we", 64'(o_vwb_reg_write_rf), 64'd0);
      clock_edge();

      s = wr(5'd5, 32'h1234);
      applyStimulus(s);
      checkOutput("t1_mux", 64'(o_wb_mux), 64'h1234);
      clock_edge();
      s = idle(); s.lk0 = 5'd5;
      applyStimulus(s);
      checkOutput("t1_h0_hit", 64'(o_lk_hit[0]), 64'd1);
      checkOutput("t1_h0_data", 64'(o_lk_data[0 +: 32]), 64'h1234);
      clock_edge();
      applyStimulus(idle());
      checkOutput("t1_vwb_rdst", 64'(o_vwb_rdst), 64'd5);
      checkOutput("t1_vwb_mux", 64'(o_vwb_mux), 64'h1234);
      clock_edge();

      cycle(wr(5'd7, 32'hA));
      cycle(wr(5'd7, 32'hB));
      s = wr(5'd0, 32'hDEAD); s.lk0 = 5'd7; s.lk1 = 5'd0;
      applyStimulus(s);
      checkOutput("t2_youngest", 64'(o_lk_data[0 +: 32]), 64'hB);
      checkOutput("t2_r0_cur", 64'(o_lk_hit[1]), 64'd0);
      clock_edge();
      s = idle(); s.lk1 = 5'd0;
      applyStimulus(s);
      checkOutput("t2_r0_hist", 64'(o_lk_hit[1]), 64'd0);
      clock_edge();

      cycle(wr(5'd9, 32'h99));
      cycle(wr(5'd10, 32'h10));
      held = hist[HIST_DEPTH-1];
      for (int i = 0; i < 3; i++) begin
         s = wr(5'(i + 11), $urandom); s.stall = 1'b1;
         cycle(s);
      end
      applyStimulus(idle());
      checkOutput("t3_stall_vwb", 64'(o_vwb_mux), 64'(held.data));
      clock_edge();
      cycle(wr(5'd9, 32'h77));
      s = idle(); s.stall = 1'b1; s.flush = 1'b1;
      cycle(s);
      s = idle(); s.lk0 = 5'd9; s.lk1 = 5'd10;
      applyStimulus(s);
      checkOutput("t3_flush_hit0", 64'(o_lk_hit[0]), 64'd0);
      checkOutput("t3_flush_hit1", 64'(o_lk_hit[1]), 64'd0);
      clock_edge();

      cycle(wr(5'd6, 32'h66));
      cycle(wr(5'd8, 32'h88));
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t4_vwb_we", 64'(o_vwb_reg_write_rf), 64'd0);
      checkOutput("t4_vwb_rdst", 64'(o_vwb_rdst), 64'd0);
      checkOutput("t4_vwb_mux", 64'(o_vwb_mux), 64'd0);
      model_reset();
      s = idle(); s.lk0 = 5'd6; s.lk1 = 5'd8;
      applyStimulus(s);
      checkOutput("t4_lk_miss", 64'(o_lk_hit), 64'd0);
      rst = 1'b1;
      clock_edge();

      cycle(wr(5'd3, 32'h33));
      cycle(wr(5'd9, 32'h99));
      s = wr(5'd3, 32'h3333); s.lk0 = 5'd3; s.lk1 = 5'd3;
      applyStimulus(s);
      checkOutput("t5_p0", 64'(o_lk_data[0 +: 32]), 64'h3333);
      checkOutput("t5_p1", 64'(o_lk_data[32 +: 32]), 64'h3333);
      clock_edge();
      s = idle(); s.lk0 = 5'd9; s.lk1 = 5'd3;
      applyStimulus(s);
      checkOutput("t5_indep0", 64'(o_lk_data[0 +: 32]), 64'h99);
      checkOutput("t5_indep1", 64'(o_lk_data[32 +: 32]), 64'h3333);
      clock_edge();

      s = idle(); s.sel = 2'b00; s.mem = 32'h80FF7F01; s.fmt = 3'b001; s.off = 2'd3;
      applyStimulus(s);
`ifdef WB_LOAD_EXT_EN
      checkOutput("t6_byte_s", 64'(o_wb_mux), 64'hFFFFFF80);
      clock_edge();
      s.fmt = 3'b010; s.off = 2'd1;
      applyStimulus(s);
      checkOutput("t6_byte_u", 64'(o_wb_mux), 64'h0000007F);
      clock_edge();
      s.fmt = 3'b011; s.off = 2'd2;
      applyStimulus(s);
      checkOutput("t6_half_s", 64'(o_wb_mux), 64'hFFFF80FF);
`else
      checkOutput("t6_pass", 64'(o_wb_mux), 64'h80FF7F01);
`endif
      clock_edge();

      for (int n = 0; n < 400; n++) begin
         s.sel   = 2'($urandom_range(0, 3));
         s.we    = 1'($urandom_range(0, 3) != 0);
         s.rdst  = 5'($urandom_range(0, 7));
         s.alu   = $urandom;
         s.mem   = $urandom;
         s.pc    = $urandom;
         s.fmt   = 3'($urandom_range(0, 7));
         s.off   = 2'($urandom_range(0, 3));
         s.stall = ($urandom_range(0, 3) == 0);
         s.flush = ($urandom_range(0, 15) == 0);
         s.lk0   = 5'($urandom_range(0, 7));
         s.lk1   = 5'($urandom_range(0, 7));
         cycle(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
